fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter width, default 32: data width, equal to the downstream fifo width.
REQ-003 SHALL have parameter BURST, default 4: maximum beats per grant, 1..15.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  N  per-requester data valid.
REQ-007 SHALL have port req_data  input  N*width  requester i occupies bits [i*width +: width].
REQ-008 SHALL have port req_ready  output  N  per-requester accept strobe.
REQ-009 SHALL have port fifo_full  input  1  full flag from the downstream fifo.
REQ-010 SHALL have port fifo_write_en  output  1  write strobe to the downstream fifo.
REQ-011 SHALL have port fifo_data_in  output  width  write data to the downstream fifo.
REQ-012 SHALL have port grant_id  output  $clog2(N)  current grantee index.
REQ-013 SHALL have port busy  output  1  high while in state GRANT.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-015 In IDLE with any req_valid high, SHALL register the round-robin winner into grant_id and enter GRANT on the next edge: one bubble cycle per grant.
REQ-016 Round-robin SHALL search indices last+1, last+2, ... mod N, where last is the previous grantee.
REQ-017 In IDLE with no req_valid high, SHALL remain in IDLE.
REQ-018 In GRANT, req_ready[grant_id] SHALL equal !fifo_full; all other req_ready bits SHALL be 0.
REQ-019 A beat SHALL be defined as GRANT & req_valid[grant_id] & !fifo_full.
REQ-020 On a beat, fifo_write_en SHALL be 1 combinationally; otherwise fifo_write_en SHALL be 0.
REQ-021 fifo_data_in SHALL equal req_data slice grant_id in GRANT, and SHALL be 0 in IDLE.
REQ-022 A beat counter SHALL increment on each beat and SHALL clear on entry to GRANT.
REQ-023 GRANT SHALL return to IDLE after the beat that brings the count to BURST, or in any cycle where req_valid[grant_id] is 0.
REQ-024 fifo_full high in GRANT SHALL stall: no beat, count held, grant held, provided req_valid[grant_id] stays 1.
REQ-025 A requester that drops valid mid-burst SHALL lose the grant; its remaining burst allowance SHALL be discarded.
REQ-026 last SHALL update to grant_id on each entry to GRANT.
REQ-027 A single active requester SHALL be re-granted after one IDLE bubble.
REQ-028 The block SHALL never assert fifo_write_en while fifo_full is 1.

Reset
REQ-029 reset SHALL asynchronously force: state IDLE, grant_id 0, last N-1, beat count 0.
REQ-030 During reset, req_ready, fifo_write_en and busy SHALL be 0, so requester 0 wins first after release.
REQ-031 Reset asserted mid-burst SHALL abort the burst with no further writes; no beat SHALL occur in the cycle reset deasserts.

Configuration
REQ-032 With macro FIFO_ARB_STATS_EN defined, SHALL add output stat_beats (N*16), where slice i counts beats accepted from requester i.
REQ-033 stat_beats slices SHALL saturate at 16'hFFFF and SHALL reset to 0.
REQ-034 Without FIFO_ARB_STATS_EN, the stat_beats port and its counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-035 Reset release, req_valid=4'b0001 held for 6 cycles, fifo_full=0 -> cycle 1 IDLE; beats 1-4 from req 0 (fifo_write_en=1); IDLE bubble; regrant of req 0.
REQ-036 req_valid=4'b1111 held, fifo_full=0, BURST=4 -> grant order 0,1,2,3,0; each grant yields exactly 4 writes, separated by one bubble.
REQ-037 req 2 granted, fifo_full=1 for 3 cycles after beat 2 -> req_ready=0 and no write for 3 cycles; beats 3-4 follow; total 4 writes.
REQ-038 req 1 granted, req_valid[1] drops after beat 1 -> IDLE next cycle; next grant goes to req 2 if valid, else wraps to 3, 0.
REQ-039 reset pulsed during beat 3 of req 3 -> fifo_write_en=0 immediately; after release, first grant is req 0.
REQ-040 With FIFO_ARB_STATS_EN, 70000 beats from req 0 -> stat_beats[15:0]=16'hFFFF; other slices 0.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter that lets N requesters write bursts of up to
// BURST beats into a single downstream fifo.
//
// A grant is won in IDLE, registered into grant_id and served in GRANT on the
// following cycles, so every grant costs one IDLE bubble. The grantee keeps the
// grant until it has written BURST beats or drops its valid; fifo_full stalls
// the burst without losing the grant.
//
// Optional feature: define FIFO_ARB_STATS_EN to add the stat_beats output,
// one saturating 16-bit accepted-beat counter per requester.
module fifo_wr_arb #(
  parameter int N     = 4,   // number of requesters, 2..8
  parameter int width = 32,  // data width, equal to the downstream fifo width
  parameter int BURST = 4    // maximum beats per grant, 1..15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req_valid,
  input  logic [N*width-1:0]     req_data,
  output logic [N-1:0]           req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_write_en,
  output logic [width-1:0]       fifo_data_in,
  output logic [$clog2(N)-1:0]   grant_id,
`ifdef FIFO_ARB_STATS_EN
  output logic [N*16-1:0]        stat_beats,
`endif
  output logic                   busy
);

  localparam int GW = $clog2(N);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [GW-1:0]   r_grant_id;
  logic [GW-1:0]   r_last;
  logic [3:0]      r_count;

  logic [GW-1:0]   w_winner;
  logic            w_any_valid;
  logic            w_cur_valid;
  logic            w_beat;
  logic [3:0]      w_count_inc;
  logic            w_burst_done;
  logic            w_take_grant;

  assign w_any_valid  = |req_valid;
  assign w_cur_valid  = req_valid[r_grant_id];
  assign w_count_inc  = r_count + 4'd1;
  assign w_burst_done = (w_count_inc == 4'(BURST));
  assign w_take_grant = (r_state == S_IDLE) && w_any_valid;

  // A beat moves one word from the grantee into the fifo; never while full.
  assign w_beat = (r_state == S_GRANT) && w_cur_valid && !fifo_full;

  // Round-robin search starting one past the previous grantee.
  always_comb begin : rr_search
    logic found;
    int   idx;
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    w_winner = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(r_last) + k) % N;
      if (!found && req_valid[idx[GW-1:0]]) begin
        w_winner = idx[GW-1:0];
        found    = 1'b1;
      end
    end
  end

  // Next-state logic: IDLE grants when anyone is valid; GRANT ends on the
  // BURST-th beat or as soon as the grantee drops valid.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any_valid) begin
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!w_cur_valid) begin
          w_state_nxt = S_IDLE;
        end else if (w_beat && w_burst_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: ready, write strobe and data mux all follow the grantee.
  always_comb begin
    req_ready     = '0;
    fifo_data_in  = '0;
    fifo_write_en = w_beat;
    busy          = (r_state == S_GRANT);
    if (r_state == S_GRANT) begin
      for (int i = 0; i < N; i++) begin
        if (r_grant_id == GW'(i)) begin
          req_ready[i] = !fifo_full;
          fifo_data_in = req_data[i*width +: width];
        end
      end
    end
  end

  assign grant_id = r_grant_id;

  // State register plus grant bookkeeping; reset makes requester 0 win first.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state always uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant_id <= '0;
      r_last     <= GW'(N - 1);
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take_grant) begin
        r_grant_id <= w_winner;
        r_last     <= w_winner;
        r_count    <= '0;
      end else if (w_beat) begin
        r_count <= w_count_inc;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] r_stat [N];

  for (genvar g = 0; g < N; g++) begin : g_stat
    // Saturating count of beats accepted from requester g.
    always_ff @(posedge clk or posedge reset) begin
      // NOTE: these counters form a small array but are observable state, so
      // each entry is reset explicitly rather than left as an unreset memory.
      if (reset) begin
        r_stat[g] <= '0;
      end else if (w_beat && (r_grant_id == GW'(g)) && (r_stat[g] != 16'hFFFF)) begin
        r_stat[g] <= r_stat[g] + 16'd1;
      end
    end
    assign stat_beats[g*16 +: 16] = r_stat[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb (N=4, width=32, BURST=4). Each requester
// presents {id, sequence} and advances its sequence on every accepted beat;
// expected fifo writes are queued as stimulus is applied and popped by a
// monitor on every observed write.
module tb_fifo_wr_arb;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int BURST = 4;

  logic             clk;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             fifo_full;
  logic             fifo_write_en;
  logic [W-1:0]     fifo_data_in;
  logic [1:0]       grant_id;
  logic             busy;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0]  stat_beats;
`endif

  fifo_wr_arb #(.N(N), .width(W), .BURST(BURST)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_full     (fifo_full),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .grant_id      (grant_id),
`ifdef FIFO_ARB_STATS_EN
    .stat_beats    (stat_beats),
`endif
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] seq     [N];
  logic [23:0] exp_seq [N];
  logic [N-1:0] acc;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Requester sources: data is {id, sequence number}.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W] = {8'(i), seq[i]};
    end
  end

  // Advance a requester's sequence after each accepted beat.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (acc[i]) seq[i] = seq[i] + 24'd1;
    end
  end

  // Monitor: sample mid-cycle, compare every write against the scoreboard.
  always @(negedge clk) begin
    logic [31:0] want;
    acc = req_valid & req_ready;
    if (fifo_write_en === 1'b1) begin
      check("write_while_full", {31'd0, fifo_full}, 32'd0);
      check("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        check("write_data", fifo_data_in, want);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input int id, input int beats);
    for (int b = 0; b < beats; b++) begin
      exp_q.push_back({8'(id), exp_seq[id]});
      exp_seq[id] = exp_seq[id] + 24'd1;
    end
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wen", {31'd0, fifo_write_en}, 32'd0);
    check("rst_ready", {28'd0, req_ready}, 32'd0);
    check("rst_gid", {30'd0, grant_id}, 32'd0);
    step();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    acc       = '0;
    for (int i = 0; i < N; i++) begin
      seq[i]     = '0;
      exp_seq[i] = '0;
    end

    // Single requester: 4 beats, bubble, regrant of the same requester.
    apply_reset();
    reset     = 1'b0;
    req_valid = 4'b0001;
    #1;
    check("t1_idle_busy", {31'd0, busy}, 32'd0);
    check("t1_idle_wen", {31'd0, fifo_write_en}, 32'd0);
    push_burst(0, 4);
    for (int b = 0; b < 4; b++) begin
      step();
      check("t1_busy", {31'd0, busy}, 32'd1);
      check("t1_wen", {31'd0, fifo_write_en}, 32'd1);
      check("t1_gid", {30'd0, grant_id}, 32'd0);
      check("t1_ready", {28'd0, req_ready}, 32'h1);
    end
    step();
    check("t1_bubble_busy", {31'd0, busy}, 32'd0);
    check("t1_bubble_wen", {31'd0, fifo_write_en}, 32'd0);
    step();
    check("t1_regrant_busy", {31'd0, busy}, 32'd1);
    check("t1_regrant_gid", {30'd0, grant_id}, 32'd0);
    req_valid = 4'b0000;
    #1;
    check("t1_drop_wen", {31'd0, fifo_write_en}, 32'd0);
    step();
    check("t1_end_busy", {31'd0, busy}, 32'd0);
    check("t1_q_empty", exp_q.size(), 32'd0);

    // All requesters valid: order 0,1,2,3,0 with 4 writes each.
    apply_reset();
    reset     = 1'b0;
    req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      push_burst(g % N, BURST);
      step();
      check("t2_gid", {30'd0, grant_id}, 32'(g % N));
      check("t2_busy", {31'd0, busy}, 32'd1);
      repeat (BURST) step();
      check("t2_bubble", {31'd0, busy}, 32'd0);
    end
    req_valid = 4'b0000;
    step();
    check("t2_q_empty", exp_q.size(), 32'd0);

    // fifo_full stall after beat 2 of requester 2.
    apply_reset();
    reset     = 1'b0;
    req_valid = 4'b0100;
    #1;
    push_burst(2, 4);
    step();
    check("t3_gid", {30'd0, grant_id}, 32'd2);
    step();
    step();
    fifo_full = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      check("t3_stall_ready", {28'd0, req_ready}, 32'd0);
      check("t3_stall_wen", {31'd0, fifo_write_en}, 32'd0);
      check("t3_stall_busy", {31'd0, busy}, 32'd1);
      step();
    end
    fifo_full = 1'b0;
    #1;
    check("t3_beat3", {31'd0, fifo_write_en}, 32'd1);
    step();
    check("t3_beat4", {31'd0, fifo_write_en}, 32'd1);
    step();
    check("t3_done", {31'd0, busy}, 32'd0);
    req_valid = 4'b0000;
    step();
    check("t3_q_empty", exp_q.size(), 32'd0);

    // Requester 1 drops after beat 1; next grant goes to 2.
    apply_reset();
    reset     = 1'b0;
    req_valid = 4'b0010;
    #1;
    push_burst(1, 1);
    step();
    check("t4_gid1", {30'd0, grant_id}, 32'd1);
    step();
    req_valid = 4'b0100;
    #1;
    check("t4_drop_wen", {31'd0, fifo_write_en}, 32'd0);
    step();
    check("t4_idle", {31'd0, busy}, 32'd0);
    push_burst(2, BURST);
    step();
    check("t4_gid2", {30'd0, grant_id}, 32'd2);
    repeat (BURST) step();
    req_valid = 4'b0000;
    step();
    check("t4_q_empty", exp_q.size(), 32'd0);

    // Same drop, but only 3 and 0 valid afterwards: wraps to 3.
    apply_reset();
    reset     = 1'b0;
    req_valid = 4'b0010;
    #1;
    push_burst(1, 1);
    step();
    step();
    req_valid = 4'b1001;
    #1;
    step();
    step();
    check("t5_gid3", {30'd0, grant_id}, 32'd3);
    req_valid = 4'b0000;
    #1;
    step();
    check("t5_q_empty", exp_q.size(), 32'd0);

    // Reset during beat 3 of requester 3, then first grant is requester 0.
    apply_reset();
    reset     = 1'b0;
    req_valid = 4'b1000;
    #1;
    push_burst(3, 2);
    step();
    check("t6_gid3", {30'd0, grant_id}, 32'd3);
    step();
    step();
    reset = 1'b1;
    #1;
    check("t6_rst_wen", {31'd0, fifo_write_en}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_ready", {28'd0, req_ready}, 32'd0);
    step();
    reset     = 1'b0;
    req_valid = 4'b1001;
    #1;
    check("t6_release_wen", {31'd0, fifo_write_en}, 32'd0);
    check("t6_release_busy", {31'd0, busy}, 32'd0);
    step();
    check("t6_gid0", {30'd0, grant_id}, 32'd0);
    req_valid = 4'b0000;
    #1;
    step();
    check("t6_q_empty", exp_q.size(), 32'd0);

`ifdef FIFO_ARB_STATS_EN
    // 70000 beats from requester 0 saturate its counter.
    apply_reset();
    check("st_reset", {16'd0, stat_beats[15:0]}, 32'd0);
    reset     = 1'b0;
    req_valid = 4'b0001;
    #1;
    for (int b = 0; b < 17500; b++) begin
      push_burst(0, BURST);
      repeat (BURST + 1) step();
    end
    req_valid = 4'b0000;
    step();
    check("st_sat0", {16'd0, stat_beats[15:0]}, 32'h0000FFFF);
    check("st_other", {16'd0, stat_beats[31:16] | stat_beats[47:32] | stat_beats[63:48]}, 32'd0);
    check("st_q_empty", exp_q.size(), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
